mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
// Two-port arbiter in front of a shared pipelined 32x32->64 unsigned multiplier.
// Latency: accept in cycle c -> resp_valid in cycle c+LATENCY+1 (one capture register after the multiplier).
// Backpressure: one operation in flight per port; a port stays ineligible until its response is consumed.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     per-port request handshake; req_ready is combinational
//   req_a, req_b            per-port 32-bit operands packed {port1, port0}
//   resp_valid/resp_ready   per-port response handshake; resp_valid is registered
//   resp_r                  per-port 64-bit products packed {port1, port0}; registered
//   mul_a, mul_b, mul_issue operands and issue strobe to the external multiplier
//   mul_r                   multiplier product, valid LATENCY cycles after its operands
//   busy                    per-port outstanding-operation flag
//
// Build option: define MUL_ARBITER_ROUND_ROBIN_EN to alternate grants when both
// ports are eligible; otherwise port 0 has fixed priority.
// LATENCY must be in 1..8 and must match the attached multiplier.

module mul_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [63:0]   req_a,
    input  logic [63:0]   req_b,
    output logic [1:0]    resp_valid,
    input  logic [1:0]    resp_ready,
    output logic [127:0]  resp_r,
    output logic [31:0]   mul_a,
    output logic [31:0]   mul_b,
    output logic          mul_issue,
    input  logic [63:0]   mul_r,
    output logic [1:0]    busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         busy_q, busy_d;
    logic [1:0]         resp_valid_q, resp_valid_d;
    logic [127:0]       resp_r_q, resp_r_d;

    // Tag pipeline: bit k describes the operation issued k+1 cycles ago.
    // The top stage lines up with the cycle in which mul_r carries its product.
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_port_q, tag_port_d;

`ifdef MUL_ARBITER_ROUND_ROBIN_EN
    // Port granted most recently; resets to 1 so port 0 wins the first tie.
    logic               last_q, last_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0]         eligible;
    logic [1:0]         grant;
    logic               issue;
    logic               issue_port;

    // A busy port is never eligible, so a response consumed in cycle n can
    // only re-arm the port from cycle n+1 onward.
    assign eligible = req_valid & ~busy_q;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
            if (eligible == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
`else
            if (eligible[0]) begin
                grant = 2'b01;
            end else if (eligible[1]) begin
                grant = 2'b10;
            end
`endif
        end
    end

    // grant only ever selects an eligible (hence valid) port, so every
    // grant is an accept.
    assign req_ready  = grant;
    assign issue      = |(req_valid & grant);
    assign issue_port = grant[1];
    assign mul_issue  = issue;

    always_comb begin
        mul_a = 32'd0;
        mul_b = 32'd0;
        if (issue) begin
            if (issue_port) begin
                mul_a = req_a[63:32];
                mul_b = req_b[63:32];
            end else begin
                mul_a = req_a[31:0];
                mul_b = req_b[31:0];
            end
        end
    end

`ifdef MUL_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        last_d = last_q;
        if (issue) begin
            last_d = issue_port;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Tag pipeline and response capture
    // ------------------------------------------------------------------
    logic               cap_vld;
    logic               cap_port;
    logic [1:0]         resp_hs;

    assign cap_vld  = tag_vld_q[LATENCY-1];
    assign cap_port = tag_port_q[LATENCY-1];
    assign resp_hs  = resp_valid_q & resp_ready;

    always_comb begin
        tag_vld_d     = '0;
        tag_port_d    = '0;
        tag_vld_d[0]  = issue;
        tag_port_d[0] = issue_port;
        for (int k = 1; k < LATENCY; k++) begin
            tag_vld_d[k]  = tag_vld_q[k-1];
            tag_port_d[k] = tag_port_q[k-1];
        end
    end

    // Capture and consume can never target the same port in one cycle: a
    // port with a pending capture is busy and its previous response was
    // already consumed before it could be granted again.
    always_comb begin
        busy_d       = busy_q;
        resp_valid_d = resp_valid_q;
        resp_r_d     = resp_r_q;

        busy_d       = busy_d & ~resp_hs;
        resp_valid_d = resp_valid_d & ~resp_hs;

        if (cap_vld) begin
            if (cap_port) begin
                resp_valid_d[1]   = 1'b1;
                resp_r_d[127:64]  = mul_r;
            end else begin
                resp_valid_d[0]   = 1'b1;
                resp_r_d[63:0]    = mul_r;
            end
        end

        busy_d = busy_d | (req_valid & grant);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_r_q     <= '0;
            tag_vld_q    <= '0;
            tag_port_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_r_q     <= resp_r_d;
            tag_vld_q    <= tag_vld_d;
            tag_port_q   <= tag_port_d;
        end
    end

`ifdef MUL_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_r     = resp_r_q;

endmodule
